uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 6 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 88 ++++++++
 tb/tb_uart_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and constants for the UART transmit arbiter
package uart_arb_pkg;
   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
   localparam logic [7:0] HEADER_TAG = 8'hA0;
   localparam int DEFAULT_MAX_LEN = 64;
endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: picks the first valid requester searching upward from last_grant+1 with wrap
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [3:0]         last_grant,
   output logic [3:0]         grant,
   output logic               any_valid
);
   logic [15:0] req_x;
   logic [4:0]  idx;
   assign req_x = 16'(req);
   assign any_valid = |req;
   // scanning from farthest to nearest lets the nearest valid candidate win
   always_comb begin
      grant = '0;
      idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = 5'(last_grant) + 5'(k);
         idx = idx >= 5'(NUM_REQ) ? idx - 5'(NUM_REQ) : idx;
         grant = req_x[idx[3:0]] ? idx[3:0] : grant;
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin multiplexer of byte-stream requesters onto one UART transmitter,
// with an optional ID header per packet and forced release after MAX_LEN payload bytes
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int HEADER_EN = 1,
   parameter int MAX_LEN   = DEFAULT_MAX_LEN
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [3:0]           grant_id,
   output logic                 busy,
   output logic                 truncated
);
   state_t     state, state_nxt;
   logic [3:0] grant, last_grant, pick;
   logic       any_valid, g_valid, g_last, xfer, pkt_end;
   logic [7:0] g_data, count;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (pick),
      .any_valid  (any_valid)
   );

   always_comb begin
      g_data = '0;
      g_valid = 1'b0;
      g_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         g_data = grant == 4'(i) ? req_data[8*i +: 8] : g_data;
         g_valid = grant == 4'(i) ? req_valid[i] : g_valid;
         g_last = grant == 4'(i) ? req_last[i] : g_last;
      end
   end

   assign xfer = tx_valid && tx_ready;
   assign pkt_end = state == PAYLOAD && xfer && (g_last || count == 8'(MAX_LEN - 1));
   assign grant_id = state == IDLE ? 4'd0 : grant;
   assign busy = state != IDLE;

   always_comb begin
      state_nxt = state;
      tx_valid = 1'b0;
      tx_data = '0;
      req_ready = '0;
      case (state)
         IDLE: state_nxt = any_valid ? (HEADER_EN != 0 ? HEADER : PAYLOAD) : IDLE;
         HEADER: begin
            tx_valid = 1'b1;
            tx_data = HEADER_TAG | {4'h0, grant};
            state_nxt = tx_ready ? PAYLOAD : HEADER;
         end
         PAYLOAD: begin
            tx_valid = g_valid;
            tx_data = g_data;
            for (int i = 0; i < NUM_REQ; i++) req_ready[i] = grant == 4'(i) && tx_ready;
            state_nxt = pkt_end ? IDLE : PAYLOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         grant <= '0;
         last_grant <= 4'(NUM_REQ - 1);
         count <= '0;
         truncated <= 1'b0;
      end else begin
         state <= state_nxt;
         truncated <= pkt_end && !g_last;
         count <= state == PAYLOAD && !pkt_end ? count + 8'(xfer) : 8'd0;
         if (state == IDLE && any_valid) grant <= pick;
         if (pkt_end) last_grant <= grant;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and a randomized
// transaction-level model check of uart_tx_arbiter
module tb_uart_tx_arbiter;
   logic        clk = 1'b0;
   logic        reset [2];
   logic [31:0] rd [2];
   logic [3:0]  rv [2], rl [2], rr [2], gid [2];
   logic        tr [2], tv [2], bsy [2], trn [2];
   logic [7:0]  td [2];
   int          checks = 0, errors = 0;
   logic [7:0]  qd [4][$];
   logic        ql [4][$];

   typedef struct packed {
      logic [3:0] v, l;
      logic [7:0] d;
      logic       r;
      logic       txv;
      logic [7:0] txd;
      logic       b;
      logic [3:0] g, rdy;
      logic       t;
   } vec_t;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(4), .HEADER_EN(1), .MAX_LEN(4)) dut_a (
      .clk(clk), .reset(reset[0]), .req_data(rd[0]), .req_valid(rv[0]), .req_last(rl[0]),
      .req_ready(rr[0]), .tx_data(td[0]), .tx_valid(tv[0]), .tx_ready(tr[0]),
      .grant_id(gid[0]), .busy(bsy[0]), .truncated(trn[0])
   );

   uart_tx_arbiter #(.NUM_REQ(4), .HEADER_EN(0), .MAX_LEN(64)) dut_b (
      .clk(clk), .reset(reset[1]), .req_data(rd[1]), .req_valid(rv[1]), .req_last(rl[1]),
      .req_ready(rr[1]), .tx_data(td[1]), .tx_valid(tv[1]), .tx_ready(tr[1]),
      .grant_id(gid[1]), .busy(bsy[1]), .truncated(trn[1])
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic [3:0] v, input logic [3:0] l,
                        input logic [31:0] data, input logic r);
      rv[d] = v;
      rl[d] = l;
      rd[d] = data;
      tr[d] = r;
   endtask

   task automatic do_reset(input int d);
      drive(d, 4'h0, 4'h0, 32'h0, 1'b1);
      reset[d] = 1'b1;
      tick;
      tick;
      reset[d] = 1'b0;
   endtask

   task automatic look(input int d, input string nm, input logic v, input logic [7:0] data,
                       input logic b, input logic [3:0] g, input logic [3:0] r, input logic t);
      chk({nm, ".tx_valid"}, 32'(tv[d]), 32'(v));
      if (v) chk({nm, ".tx_data"}, 32'(td[d]), 32'(data));
      chk({nm, ".busy"}, 32'(bsy[d]), 32'(b));
      chk({nm, ".grant_id"}, 32'(gid[d]), 32'(g));
      chk({nm, ".req_ready"}, 32'(rr[d]), 32'(r));
      chk({nm, ".truncated"}, 32'(trn[d]), 32'(t));
   endtask

   // Expected stream is built per grant from the packet queues, then compared
   // byte-by-byte with tx transfers while requesters and tx_ready behave randomly.
   task automatic rand_test(input int d);
      int         maxl = d != 0 ? 64 : 4;
      bit         hdr = d == 0;
      logic [11:0] exp [$];
      int         idx [4], seg [4], pos [4];
      int         last = 3, ntr = 0, tr_exp = 0, ei = 0, cyc = 0, tail = 0;
      logic [3:0] acc;
      for (int r = 0; r < 4; r++) begin
         int npk = $urandom_range(1, 3);
         qd[r].delete();
         ql[r].delete();
         idx[r] = 0;
         seg[r] = 0;
         pos[r] = 0;
         for (int p = 0; p < npk; p++) begin
            int len = $urandom_range(1, 9);
            for (int b = 0; b < len; b++) begin
               qd[r].push_back(8'($urandom));
               ql[r].push_back(b == len - 1);
            end
         end
      end
      for (int n = 0; n < 64; n++) begin
         int r = -1;
         for (int k = 1; k <= 4; k++)
            if (r < 0 && pos[(last + k) % 4] < qd[(last + k) % 4].size()) r = (last + k) % 4;
         if (r >= 0) begin
            bit lf = 1'b0;
            int cnt = 0;
            if (hdr) exp.push_back({4'(r), 8'hA0 | 8'(r)});
            while (!lf && cnt < maxl) begin
               exp.push_back({4'(r), qd[r][pos[r]]});
               lf = ql[r][pos[r]];
               pos[r]++;
               cnt++;
            end
            if (!lf) tr_exp++;
            last = r;
         end
      end
      do_reset(d);
      while (cyc < 4000 && tail < 3) begin
         for (int r = 0; r < 4; r++) begin
            bit v = idx[r] < qd[r].size() && !(seg[r] != 0 && $urandom_range(0, 3) == 0);
            rv[d][r] = v;
            rd[d][8*r +: 8] = v ? qd[r][idx[r]] : 8'($urandom);
            rl[d][r] = v ? ql[r][idx[r]] : 1'($urandom);
         end
         tr[d] = $urandom_range(0, 3) != 0;
         @(negedge clk);
         if (tv[d] && tr[d]) begin
            if (ei < exp.size()) chk($sformatf("rand%0d_tx%0d", d, ei), 32'({gid[d], td[d]}), 32'(exp[ei]));
            else begin
               checks++;
               errors++;
               $display("FAIL rand%0d_extra: got byte %0h from grant %0d, expected none", d, td[d], gid[d]);
            end
            ei++;
         end
         acc = rv[d] & rr[d];
         ntr += int'(trn[d]);
         tail += ei >= exp.size() ? 1 : 0;
         cyc++;
         tick;
         for (int r = 0; r < 4; r++)
            if (acc[r]) begin
               seg[r] = (ql[r][idx[r]] || seg[r] + 1 == maxl) ? 0 : seg[r] + 1;
               idx[r]++;
            end
      end
      chk($sformatf("rand%0d_done", d), 32'(ei), 32'(exp.size()));
      chk($sformatf("rand%0d_trunc", d), 32'(ntr), 32'(tr_exp));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl [17];
      logic [3:0] g;
      reset[0] = 1'b1;
      reset[1] = 1'b1;
      drive(0, 4'h0, 4'h0, 32'h0, 1'b1);
      drive(1, 4'h0, 4'h0, 32'h0, 1'b1);
      tbl[0]  = '{4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b0};
      tbl[1]  = '{4'h2, 4'h0, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b0};
      tbl[2]  = '{4'h2, 4'h0, 8'h55, 1'b1, 1'b1, 8'hA1, 1'b1, 4'd1, 4'h0, 1'b0};
      tbl[3]  = '{4'h2, 4'h0, 8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 4'd1, 4'h2, 1'b0};
      tbl[4]  = '{4'h2, 4'h2, 8'h66, 1'b1, 1'b1, 8'h66, 1'b1, 4'd1, 4'h2, 1'b0};
      tbl[5]  = '{4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b0};
      tbl[6]  = '{4'h8, 4'h0, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b0};
      tbl[7]  = '{4'h8, 4'h0, 8'h10, 1'b1, 1'b1, 8'hA3, 1'b1, 4'd3, 4'h0, 1'b0};
      tbl[8]  = '{4'h8, 4'h0, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 4'd3, 4'h8, 1'b0};
      tbl[9]  = '{4'h8, 4'h0, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 4'd3, 4'h8, 1'b0};
      tbl[10] = '{4'h8, 4'h0, 8'h12, 1'b1, 1'b1, 8'h12, 1'b1, 4'd3, 4'h8, 1'b0};
      tbl[11] = '{4'h8, 4'h0, 8'h13, 1'b1, 1'b1, 8'h13, 1'b1, 4'd3, 4'h8, 1'b0};
      tbl[12] = '{4'h8, 4'h0, 8'h14, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b1};
      tbl[13] = '{4'h8, 4'h0, 8'h14, 1'b1, 1'b1, 8'hA3, 1'b1, 4'd3, 4'h0, 1'b0};
      tbl[14] = '{4'h8, 4'h0, 8'h14, 1'b1, 1'b1, 8'h14, 1'b1, 4'd3, 4'h8, 1'b0};
      tbl[15] = '{4'h8, 4'h8, 8'h15, 1'b1, 1'b1, 8'h15, 1'b1, 4'd3, 4'h8, 1'b0};
      tbl[16] = '{4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b0};
      do_reset(1);
      do_reset(0);
      for (int i = 0; i < 17; i++) begin
         drive(0, tbl[i].v, tbl[i].l, {4{tbl[i].d}}, tbl[i].r);
         @(negedge clk);
         look(0, $sformatf("vec%0d", i), tbl[i].txv, tbl[i].txd, tbl[i].b, tbl[i].g, tbl[i].rdy, tbl[i].t);
         tick;
      end

      // requesters 0 and 2 always valid with 1-byte packets: 0,2,0,2 with one idle cycle between
      do_reset(0);
      drive(0, 4'b0101, 4'b0101, 32'h0032_0030, 1'b1);
      for (int c = 0; c < 12; c++) begin
         g = (c / 3) % 2 != 0 ? 4'd2 : 4'd0;
         @(negedge clk);
         if (c % 3 == 0) look(0, "rr_idle", 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b0);
         else if (c % 3 == 1) look(0, "rr_hdr", 1'b1, 8'hA0 | 8'(g), 1'b1, g, 4'h0, 1'b0);
         else look(0, "rr_pay", 1'b1, 8'h30 | 8'(g), 1'b1, g, g != 0 ? 4'b0100 : 4'b0001, 1'b0);
         tick;
      end

      // tx_ready stalled for 10 cycles in payload
      do_reset(0);
      drive(0, 4'b0010, 4'b0000, 32'h0000_7100, 1'b1);
      @(negedge clk); look(0, "stall_idle", 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b0); tick;
      @(negedge clk); look(0, "stall_hdr", 1'b1, 8'hA1, 1'b1, 4'd1, 4'h0, 1'b0); tick;
      @(negedge clk); look(0, "stall_b1", 1'b1, 8'h71, 1'b1, 4'd1, 4'b0010, 1'b0); tick;
      rd[0] = 32'h0000_7200;
      tr[0] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         look(0, $sformatf("stall_hold%0d", c), 1'b1, 8'h72, 1'b1, 4'd1, 4'h0, 1'b0);
         tick;
      end
      tr[0] = 1'b1;
      @(negedge clk); look(0, "stall_b2", 1'b1, 8'h72, 1'b1, 4'd1, 4'b0010, 1'b0); tick;
      rd[0] = 32'h0000_7300;
      rl[0] = 4'b0010;
      @(negedge clk); look(0, "stall_b3", 1'b1, 8'h73, 1'b1, 4'd1, 4'b0010, 1'b0); tick;
      drive(0, 4'h0, 4'h0, 32'h0, 1'b1);
      @(negedge clk); look(0, "stall_end", 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b0); tick;

      // reset after two of five payload bytes
      do_reset(0);
      drive(0, 4'b0100, 4'b0000, 32'h00c1_0000, 1'b1);
      @(negedge clk); look(0, "rst_idle", 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b0); tick;
      @(negedge clk); look(0, "rst_hdr", 1'b1, 8'hA2, 1'b1, 4'd2, 4'h0, 1'b0); tick;
      @(negedge clk); look(0, "rst_b1", 1'b1, 8'hC1, 1'b1, 4'd2, 4'b0100, 1'b0); tick;
      rd[0] = 32'h00c2_0000;
      @(negedge clk); look(0, "rst_b2", 1'b1, 8'hC2, 1'b1, 4'd2, 4'b0100, 1'b0); tick;
      rd[0] = 32'h00c3_0000;
      reset[0] = 1'b1;
      tick;
      reset[0] = 1'b0;
      drive(0, 4'b0101, 4'b0000, 32'h00c3_00e0, 1'b1);
      @(negedge clk); look(0, "rst_after", 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b0); tick;
      @(negedge clk); look(0, "rst_regrant", 1'b1, 8'hA0, 1'b1, 4'd0, 4'h0, 1'b0); tick;

      // no header; requester 1 pauses mid-packet while requester 0 waits
      do_reset(1);
      drive(1, 4'b0010, 4'b0000, 32'h0000_8100, 1'b1);
      @(negedge clk); look(1, "gap_idle", 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b0); tick;
      drive(1, 4'b0011, 4'b0001, 32'h0000_8190, 1'b1);
      @(negedge clk); look(1, "gap_b1", 1'b1, 8'h81, 1'b1, 4'd1, 4'b0010, 1'b0); tick;
      rd[1] = 32'h0000_8290;
      @(negedge clk); look(1, "gap_b2", 1'b1, 8'h82, 1'b1, 4'd1, 4'b0010, 1'b0); tick;
      rv[1] = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         look(1, $sformatf("gap_hold%0d", c), 1'b0, 8'h00, 1'b1, 4'd1, 4'b0010, 1'b0);
         tick;
      end
      rv[1] = 4'b0011;
      rd[1] = 32'h0000_8390;
      @(negedge clk); look(1, "gap_b3", 1'b1, 8'h83, 1'b1, 4'd1, 4'b0010, 1'b0); tick;
      rd[1] = 32'h0000_8490;
      rl[1] = 4'b0011;
      @(negedge clk); look(1, "gap_b4", 1'b1, 8'h84, 1'b1, 4'd1, 4'b0010, 1'b0); tick;
      rv[1] = 4'b0001;
      @(negedge clk); look(1, "gap_idle2", 1'b0, 8'h00, 1'b0, 4'd0, 4'h0, 1'b0); tick;
      @(negedge clk); look(1, "gap_r0", 1'b1, 8'h90, 1'b1, 4'd0, 4'b0001, 1'b0); tick;
      drive(1, 4'h0, 4'h0, 32'h0, 1'b1);

      rand_test(0);
      rand_test(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
